// File: rtl/mod_counter_hex_if.sv
// rtl/mod_counter_hex_if.sv - control, count and display bundle for mod_counter_hex
interface mod_counter_hex_if #(
  parameter int WIDTH = 8
);
  localparam int DIGITS = (WIDTH + 3) / 4;

  logic                  enable;
  logic                  up;
  logic                  load;
  logic [WIDTH-1:0]      load_value;
  logic [WIDTH-1:0]      count;
  logic                  tc;
  logic [7*DIGITS-1:0]   hex;

  modport master (
    output enable, up, load, load_value,
    input  count, tc, hex
  );

  modport slave (
    input  enable, up, load, load_value,
    output count, tc, hex
  );
endinterface

// File: rtl/mod_counter_hex.sv
// rtl/mod_counter_hex.sv - modulo-N up/down counter with prescaler, load, tc pulse and hex decode
module mod_counter_hex #(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter int PRESCALE = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  mod_counter_hex_if.slave  bus
);
  localparam int DIGITS = (WIDTH + 3) / 4;
  localparam int PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [WIDTH:0]   MOD_W    = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MODULUS - 1);
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tc_q, tc_d;
  logic             tick;

  assign tick = bus.enable && (pre_q == PRE_LAST);

  always_comb begin
    count_d = count_q;
    pre_d   = pre_q;
    tc_d    = 1'b0;
    if (bus.load) begin
      count_d = ({1'b0, bus.load_value} < MOD_W) ? bus.load_value : MAX_V;
      pre_d   = '0;
    end else if (tick) begin
      pre_d = '0;
      if (bus.up) begin
        if (count_q == MAX_V) begin
          count_d = '0;
          tc_d    = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          count_d = MAX_V;
          tc_d    = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end else if (bus.enable) begin
      pre_d = pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
      pre_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      pre_q   <= pre_d;
      tc_q    <= tc_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;

  // Segment patterns are g..a, active-low.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  logic [4*DIGITS-1:0] count_ext;
  assign count_ext = (4 * DIGITS)'(count_q);

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    assign bus.hex[7*k +: 7] = seg7(count_ext[4*k +: 4]);
  end
endmodule

// File: tb/tb_mod_counter_hex.sv
// tb/tb_mod_counter_hex.sv - scoreboard bench for mod_counter_hex over four parameter sets
module tb_mod_counter_hex;
  logic       clk = 1'b0;
  logic [3:0] rst = 4'hF;

  always #5 clk = ~clk;

  // u0: W8/M256/P1, u1: W4/M10/P1, u2: W8/M256/P4, u3: W4/M10/P3
  mod_counter_hex_if #(.WIDTH(8)) if0 ();
  mod_counter_hex_if #(.WIDTH(4)) if1 ();
  mod_counter_hex_if #(.WIDTH(8)) if2 ();
  mod_counter_hex_if #(.WIDTH(4)) if3 ();

  mod_counter_hex #(.WIDTH(8), .MODULUS(256), .PRESCALE(1)) u0 (.clk_i(clk), .reset_i(rst[0]), .bus(if0.slave));
  mod_counter_hex #(.WIDTH(4), .MODULUS(10),  .PRESCALE(1)) u1 (.clk_i(clk), .reset_i(rst[1]), .bus(if1.slave));
  mod_counter_hex #(.WIDTH(8), .MODULUS(256), .PRESCALE(4)) u2 (.clk_i(clk), .reset_i(rst[2]), .bus(if2.slave));
  mod_counter_hex #(.WIDTH(4), .MODULUS(10),  .PRESCALE(3)) u3 (.clk_i(clk), .reset_i(rst[3]), .bus(if3.slave));

  typedef struct {
    int          id;
    logic [15:0] cnt;
    logic        tc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   step_no  = 0;
  int   tc_seen;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int id, input logic r, input logic en, input logic u,
                       input logic ld, input logic [15:0] lv);
    rst[id] = r;
    case (id)
      0: begin if0.enable = en; if0.up = u; if0.load = ld; if0.load_value = lv[7:0]; end
      1: begin if1.enable = en; if1.up = u; if1.load = ld; if1.load_value = lv[3:0]; end
      2: begin if2.enable = en; if2.up = u; if2.load = ld; if2.load_value = lv[7:0]; end
      default: begin if3.enable = en; if3.up = u; if3.load = ld; if3.load_value = lv[3:0]; end
    endcase
  endtask

  function automatic logic [16:0] observe(input int id);
    case (id)
      0: observe = {if0.tc, 8'h0, if0.count};
      1: observe = {if1.tc, 12'h0, if1.count};
      2: observe = {if2.tc, 8'h0, if2.count};
      default: observe = {if3.tc, 12'h0, if3.count};
    endcase
  endfunction

  task automatic pop_check();
    exp_t        e;
    logic [16:0] o;
    e = sb.pop_front();
    o = observe(e.id);
    check_eq($sformatf("u%0d_step%0d_count", e.id, step_no), 32'(o[15:0]), 32'(e.cnt));
    check_eq($sformatf("u%0d_step%0d_tc", e.id, step_no), 32'(o[16]), 32'(e.tc));
  endtask

  task automatic step(input int id, input logic r, input logic en, input logic u, input logic ld,
                      input logic [15:0] lv, input logic [15:0] ecnt, input logic etc);
    drive(id, r, en, u, ld, lv);
    sb.push_back('{id: id, cnt: ecnt, tc: etc});
    @(posedge clk);
    #1;
    step_no++;
    pop_check();
  endtask

  initial begin
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    drive(1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    drive(2, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    drive(3, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    @(posedge clk);
    #1;
    rst[3:1] = 3'b000;

    // Reset overrides enable and load
    step(0, 1, 1, 1, 1, 16'hAB, 16'h00, 0);
    step(0, 1, 1, 1, 1, 16'hAB, 16'h00, 0);
    check_eq("u0_hex_reset", 32'(if0.hex), 32'(14'b1000000_1000000));

    // Up wrap through 0xFF
    step(0, 0, 0, 1, 1, 16'hFE, 16'hFE, 0);
    step(0, 0, 1, 1, 0, 16'h00, 16'hFF, 0);
    check_eq("u0_hex_ff", 32'(if0.hex), 32'(14'b0001110_0001110));
    step(0, 0, 1, 1, 0, 16'h00, 16'h00, 1);
    check_eq("u0_hex_00", 32'(if0.hex), 32'(14'b1000000_1000000));
    step(0, 0, 1, 1, 0, 16'h00, 16'h01, 0);
    check_eq("u0_hex_01", 32'(if0.hex), 32'(14'b1000000_1111001));

    // Load on a tick edge suppresses the step
    step(0, 0, 1, 1, 1, 16'h05, 16'h05, 0);
    step(0, 0, 1, 1, 0, 16'h00, 16'h06, 0);
    check_eq("u0_hex_06", 32'(if0.hex), 32'(14'b1000000_0000010));
    step(0, 1, 1, 1, 1, 16'h09, 16'h00, 0);
    step(0, 0, 1, 0, 0, 16'h00, 16'hFF, 1);
    step(0, 0, 0, 0, 0, 16'h00, 16'hFF, 0);

    // Modulus 10: down wrap, clamped load, full up cycle
    step(1, 0, 1, 0, 0, 16'h0, 16'h9, 1);
    check_eq("u1_hex_9", 32'(if1.hex), 32'(7'b0010000));
    step(1, 0, 0, 0, 1, 16'hC, 16'h9, 0);
    step(1, 0, 0, 0, 1, 16'h3, 16'h3, 0);
    step(1, 0, 0, 0, 1, 16'hF, 16'h9, 0);
    step(1, 0, 1, 1, 0, 16'h0, 16'h0, 1);
    step(1, 0, 1, 1, 0, 16'h0, 16'h1, 0);
    step(1, 0, 1, 0, 0, 16'h0, 16'h0, 0);
    tc_seen = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1, 0, 1, 1, 0, 16'h0, 16'(i % 10), (i == 10));
      tc_seen += int'(if1.tc);
    end
    check_eq("u1_tc_pulses", 32'(tc_seen), 32'd1);
    step(1, 0, 0, 1, 0, 16'h0, 16'h0, 0);

    // Prescale 4 with an enable gap
    for (int i = 0; i < 3; i++) step(2, 0, 1, 1, 0, 16'h0, 16'h0, 0);
    for (int i = 0; i < 5; i++) step(2, 0, 0, 1, 0, 16'h0, 16'h0, 0);
    step(2, 0, 1, 1, 0, 16'h0, 16'h1, 0);
    for (int i = 1; i <= 8; i++) step(2, 0, 1, 1, 0, 16'h0, 16'(1 + i / 4), 0);
    for (int i = 0; i < 3; i++) step(2, 0, 1, 1, 0, 16'h0, 16'h3, 0);
    step(2, 0, 1, 1, 1, 16'h5, 16'h5, 0);
    for (int i = 0; i < 3; i++) step(2, 0, 1, 1, 0, 16'h0, 16'h5, 0);
    step(2, 0, 1, 1, 0, 16'h0, 16'h6, 0);
    step(2, 0, 0, 1, 0, 16'h0, 16'h6, 0);

    // Prescale 3, reset mid-prescale while counting down
    step(3, 0, 1, 0, 0, 16'h0, 16'h0, 0);
    step(3, 0, 1, 0, 0, 16'h0, 16'h0, 0);
    step(3, 1, 1, 0, 0, 16'h0, 16'h0, 0);
    step(3, 0, 1, 0, 0, 16'h0, 16'h0, 0);
    step(3, 0, 1, 0, 0, 16'h0, 16'h0, 0);
    step(3, 0, 1, 0, 0, 16'h0, 16'h9, 1);
    step(3, 0, 1, 0, 0, 16'h0, 16'h9, 0);
    check_eq("u3_hex_9", 32'(if3.hex), 32'(7'b0010000));

    check_eq("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
